sdram_cmd_sequencer: RTL and testbench

//  Host-side command sequencer placed in front of sdram_controls. It accepts one

---
 rtl/sdram_cmd_sequencer_if.sv | 31 +++
 rtl/sdram_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_sdram_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_sequencer_if.sv
// Host request bus and SDRAM command pin bundle for sdram_cmd_sequencer.
// The master side issues requests; the slave side is the sequencer itself.
interface sdram_cmd_sequencer_if;
  logic        Req;
  logic        ReqWe;
  logic [31:0] ReqAddr;
  logic [1:0]  ReqSize;
  logic [7:0]  tpre;
  logic [7:0]  twait;
  logic [7:0]  tcas;
  logic [7:0]  tburst;
  logic        ReqAck;
  logic        Done;
  logic        Busy;
  logic        CS;
  logic        RAS;
  logic        CAS;
  logic        WeIn;
  logic [31:0] AddrIn;
  logic [1:0]  SizeIn;

  modport master (
    output Req, ReqWe, ReqAddr, ReqSize, tpre, twait, tcas, tburst,
    input  ReqAck, Done, Busy, CS, RAS, CAS, WeIn, AddrIn, SizeIn
  );

  modport slave (
    input  Req, ReqWe, ReqAddr, ReqSize, tpre, twait, tcas, tburst,
    output ReqAck, Done, Busy, CS, RAS, CAS, WeIn, AddrIn, SizeIn
  );
endinterface

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: turns one host read/write request at a time into a
// PRECHARGE -> ACTIVATE -> READ/WRITE pin sequence, skipping PRE/ACT on an
// open-row hit. Command pins are decoded from the state so every command lasts
// exactly one cycle and all other cycles drive NOP.
module sdram_cmd_sequencer #(
  parameter bit OPEN_PAGE = 1'b1,
  parameter int ROW_LSB   = 8,
  parameter int FIELD_W   = 8
) (
  input logic                 Clk,
  input logic                 Rst,
  sdram_cmd_sequencer_if.slave bus
);

  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;

  typedef enum logic [2:0] {
    IDLE, PRE, PRE_W, ACT, ACT_W, RW, XFER_W, DONE
  } stateT;

  stateT               state, nextState;
  logic [9:0]          cnt, cntNext;
  logic                rowOpen;
  logic [FIELD_W-1:0]  openRow;
  logic [FIELD_W-1:0]  latRow, latCol;
  logic                latWe;
  logic [1:0]          latSize;
  logic [7:0]          latTpre, latTwait, latTcas, latTburst;
  logic [FIELD_W-1:0]  reqRow;
  logic                accept;
  logic [3:0]          cmd;
  logic [31:0]         addrOut;
  logic                ackOut, doneOut, busyOut;

  // A zero timing value still needs one wait cycle between commands.
  function automatic logic [9:0] atLeastOne(input logic [7:0] t);
    return (t == 8'd0) ? 10'd1 : {2'b00, t};
  endfunction

  assign reqRow = bus.ReqAddr[ROW_LSB +: FIELD_W];
  assign accept = (state == IDLE) && bus.Req && Rst;

  // Next-state, wait counter reload and command/handshake decode.
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    cmd       = CMD_NOP;
    addrOut   = '0;
    ackOut    = 1'b0;
    doneOut   = 1'b0;
    busyOut   = 1'b1;
    case (state)
      IDLE: begin
        busyOut = accept;
        if (accept) begin
          ackOut = 1'b1;
          if (!OPEN_PAGE)                         nextState = PRE;
          else if (rowOpen && reqRow == openRow) nextState = RW;
          else if (rowOpen)                       nextState = PRE;
          else                                    nextState = ACT;
        end
      end
      PRE: begin
        cmd       = CMD_PRE;
        cntNext   = atLeastOne(latTpre);
        nextState = PRE_W;
      end
      PRE_W: begin
        if (cnt <= 10'd1) nextState = ACT;
        else              cntNext   = cnt - 10'd1;
      end
      ACT: begin
        cmd       = CMD_ACT;
        addrOut   = {{(32-FIELD_W){1'b0}}, latRow};
        cntNext   = atLeastOne(latTwait);
        nextState = ACT_W;
      end
      ACT_W: begin
        if (cnt <= 10'd1) nextState = RW;
        else              cntNext   = cnt - 10'd1;
      end
      RW: begin
        cmd       = latWe ? CMD_WR : CMD_RD;
        addrOut   = {{(32-FIELD_W){1'b0}}, latCol};
        cntNext   = (latWe ? 10'd0 : {2'b00, latTcas}) + atLeastOne(latTburst)
                    + {2'b00, latTwait};
        nextState = XFER_W;
      end
      XFER_W: begin
        if (cnt <= 10'd1) nextState = DONE;
        else              cntNext   = cnt - 10'd1;
      end
      DONE: begin
        doneOut   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // State, counter, request latches and open-row tracking.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rowOpen   <= 1'b0;
      openRow   <= '0;
      latRow    <= '0;
      latCol    <= '0;
      latWe     <= 1'b0;
      latSize   <= '0;
      latTpre   <= '0;
      latTwait  <= '0;
      latTcas   <= '0;
      latTburst <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
      if (accept) begin
        latRow    <= reqRow;
        latCol    <= bus.ReqAddr[FIELD_W-1:0];
        latWe     <= bus.ReqWe;
        latSize   <= bus.ReqSize;
        latTpre   <= bus.tpre;
        latTwait  <= bus.twait;
        latTcas   <= bus.tcas;
        latTburst <= bus.tburst;
      end
      if (state == PRE) rowOpen <= 1'b0;
      if (state == ACT) begin
        rowOpen <= 1'b1;
        openRow <= latRow;
      end
      if (state == DONE && !OPEN_PAGE) rowOpen <= 1'b0;
    end
  end

  assign {bus.CS, bus.RAS, bus.CAS, bus.WeIn} = cmd;
  assign bus.AddrIn = addrOut;
  assign bus.SizeIn = latSize;
  assign bus.ReqAck = ackOut;
  assign bus.Done   = doneOut;
  assign bus.Busy   = busyOut;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Testbench for sdram_cmd_sequencer: one open-page and one closed-page instance,
// each request checked cycle by cycle against a sequence built from the
// command/timing rules and a tracked open-row model.
module tb_sdram_cmd_sequencer;

  localparam logic [3:0] NOP = 4'b1111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] RD  = 4'b0101;
  // Bundle layout: ack[40] done[39] busy[38] size[37:36] pins[35:32] addr[31:0]
  localparam logic [40:0] NOSIZE = ~(41'h3 << 36);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqO = 1'b0, reqC = 1'b0, reqWe = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [1:0]  reqSize = '0;
  logic [7:0]  tPre = '0, tWait = '0, tCas = '0, tBurst = '0;
  int          total = 0;
  int          bad = 0;
  bit          mRowOpen [2];
  logic [7:0]  mOpenRow [2];
  logic [40:0] obs [2];

  always #5 clk = ~clk;

  sdram_cmd_sequencer_if busO ();
  sdram_cmd_sequencer_if busC ();

  assign busO.Req = reqO;       assign busC.Req = reqC;
  assign busO.ReqWe = reqWe;    assign busC.ReqWe = reqWe;
  assign busO.ReqAddr = reqAddr; assign busC.ReqAddr = reqAddr;
  assign busO.ReqSize = reqSize; assign busC.ReqSize = reqSize;
  assign busO.tpre = tPre;      assign busC.tpre = tPre;
  assign busO.twait = tWait;    assign busC.twait = tWait;
  assign busO.tcas = tCas;      assign busC.tcas = tCas;
  assign busO.tburst = tBurst;  assign busC.tburst = tBurst;

  sdram_cmd_sequencer #(.OPEN_PAGE(1'b1), .ROW_LSB(8), .FIELD_W(8)) dutOpen (
    .Clk(clk), .Rst(rst), .bus(busO.slave));
  sdram_cmd_sequencer #(.OPEN_PAGE(1'b0), .ROW_LSB(8), .FIELD_W(8)) dutClosed (
    .Clk(clk), .Rst(rst), .bus(busC.slave));

  assign obs[0] = {busO.ReqAck, busO.Done, busO.Busy, busO.SizeIn,
                   busO.CS, busO.RAS, busO.CAS, busO.WeIn, busO.AddrIn};
  assign obs[1] = {busC.ReqAck, busC.Done, busC.Busy, busC.SizeIn,
                   busC.CS, busC.RAS, busC.CAS, busC.WeIn, busC.AddrIn};

  function automatic logic [40:0] mk(input logic a, input logic d, input logic b,
                                     input logic [1:0] s, input logic [3:0] p,
                                     input logic [31:0] ad);
    return {a, d, b, s, p, ad};
  endfunction

  function automatic int atLeast1(input logic [7:0] t);
    return (t == 8'd0) ? 1 : int'(t);
  endfunction

  task automatic scrambleInputs();
    reqWe   = 1'($urandom);
    reqAddr = $urandom;
    reqSize = 2'($urandom);
    tPre    = 8'($urandom);
    tWait   = 8'($urandom);
    tCas    = 8'($urandom);
    tBurst  = 8'($urandom);
  endtask

  task automatic checkIdle(input int w, input string name, input logic [1:0] size);
    total++;
    if (obs[w] !== mk(1'b0, 1'b0, 1'b0, size, NOP, 32'h0)) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, obs[w],
               mk(1'b0, 1'b0, 1'b0, size, NOP, 32'h0));
    end
  endtask

  // Accepts one request on instance w and follows it cycle by cycle to Done.
  task automatic doRequest(input int w, input string name, input logic we,
                           input logic [31:0] addr, input logic [1:0] size,
                           input logic [7:0] tp, input logic [7:0] tw,
                           input logic [7:0] tc, input logic [7:0] tb,
                           input bit holdReq, input int abortAfter);
    logic [40:0] expQ [$];
    logic [7:0]  row, col;
    int          path, xfer, n;
    bit          ok;
    row = addr[15:8];
    col = addr[7:0];
    if (w == 0 && mRowOpen[0] && mOpenRow[0] == row) path = 0;
    else if (w == 1 || mRowOpen[w])                    path = 1;
    else                                               path = 2;
    if (path == 1) begin
      expQ.push_back(mk(1'b0, 1'b0, 1'b1, size, PRE, 32'h0));
      repeat (atLeast1(tp)) expQ.push_back(mk(1'b0, 1'b0, 1'b1, size, NOP, 32'h0));
    end
    if (path != 0) begin
      expQ.push_back(mk(1'b0, 1'b0, 1'b1, size, ACT, {24'h0, row}));
      repeat (atLeast1(tw)) expQ.push_back(mk(1'b0, 1'b0, 1'b1, size, NOP, 32'h0));
    end
    expQ.push_back(mk(1'b0, 1'b0, 1'b1, size, we ? WR : RD, {24'h0, col}));
    xfer = (we ? 0 : int'(tc)) + atLeast1(tb) + int'(tw);
    repeat (xfer) expQ.push_back(mk(1'b0, 1'b0, 1'b1, size, NOP, 32'h0));
    expQ.push_back(mk(1'b0, 1'b1, 1'b1, size, NOP, 32'h0));

    @(negedge clk);
    reqWe = we; reqAddr = addr; reqSize = size;
    tPre = tp; tWait = tw; tCas = tc; tBurst = tb;
    if (w == 0) reqO = 1'b1; else reqC = 1'b1;
    #1;
    total++;
    if ((obs[w] & NOSIZE) !== (mk(1'b1, 1'b0, 1'b1, 2'b00, NOP, 32'h0) & NOSIZE)) begin
      bad++;
      $display("[TB] FAIL %s accept: got %h want %h (size ignored)", name, obs[w],
               mk(1'b1, 1'b0, 1'b1, 2'b00, NOP, 32'h0));
    end

    ok = 1'b1;
    foreach (expQ[i]) begin
      if (abortAfter >= 0 && i >= abortAfter) break;
      @(negedge clk);
      if (!holdReq) begin reqO = 1'b0; reqC = 1'b0; end
      scrambleInputs();
      #1;
      total++;
      if (obs[w] !== expQ[i]) begin
        bad++;
        ok = 1'b0;
        $display("[TB] FAIL %s cycle %0d: got %h want %h", name, i, obs[w], expQ[i]);
        break;
      end
    end

    if (!ok) begin
      reqO = 1'b0; reqC = 1'b0;
      n = 0;
      while (obs[w][38] && n < 2000) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 2000) begin
        total++;
        bad++;
        $display("[TB] FAIL %s drain: busy stuck got 1 want 0", name);
      end
    end

    if (path != 0) begin
      mRowOpen[w] = 1'b1;
      mOpenRow[w] = row;
    end
    if (w == 1) mRowOpen[w] = 1'b0;

    if (ok && !holdReq && abortAfter < 0) begin
      @(negedge clk);
      #1;
      checkIdle(w, {name, " idleAfter"}, size);
    end
  endtask

  task automatic test_reset();
    mRowOpen[0] = 1'b0; mRowOpen[1] = 1'b0;
    mOpenRow[0] = 8'h0; mOpenRow[1] = 8'h0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkIdle(0, "resetOpen", 2'b00);
    checkIdle(1, "resetClosed", 2'b00);
    reqO = 1'b1; reqC = 1'b1;
    @(negedge clk);
    #1;
    checkIdle(0, "resetReqOpen", 2'b00);
    checkIdle(1, "resetReqClosed", 2'b00);
    reqO = 1'b0; reqC = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_cold_write();
    doRequest(0, "coldWrite", 1'b1, 32'h000AA0BB, 2'd1, 8'd3, 8'd3, 8'd0, 8'd8, 1'b0, -1);
  endtask

  task automatic test_row_hit();
    doRequest(0, "rowHit", 1'b0, 32'h0000A0C3, 2'd2, 8'd3, 8'd3, 8'd5, 8'd8, 1'b0, -1);
  endtask

  task automatic test_row_miss();
    doRequest(0, "rowMiss", 1'b0, 32'h00001234, 2'd3, 8'd3, 8'd3, 8'd2, 8'd4, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    doRequest(0, "hitAbort", 1'b0, 32'h00001255, 2'd1, 8'd3, 8'd2, 8'd4, 8'd4, 1'b0, 6);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkIdle(0, "rstMid1", 2'b00);
    @(negedge clk);
    #1;
    checkIdle(0, "rstMid2", 2'b00);
    checkIdle(1, "rstMidClosed", 2'b00);
    mRowOpen[0] = 1'b0; mRowOpen[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkIdle(0, "rstMidNoDone", 2'b00);
      @(negedge clk);
    end
  endtask

  task automatic test_after_reset();
    doRequest(0, "afterRstOpen", 1'b0, 32'h00001266, 2'd2, 8'd2, 8'd2, 8'd1, 8'd2, 1'b0, -1);
    doRequest(1, "afterRstClosed", 1'b0, 32'h00001266, 2'd2, 8'd2, 8'd2, 8'd1, 8'd2, 1'b0, -1);
  endtask

  task automatic test_closed_page();
    doRequest(1, "closed1", 1'b1, 32'h000AA0BB, 2'd2, 8'd2, 8'd2, 8'd0, 8'd3, 1'b0, -1);
    doRequest(1, "closed2", 1'b1, 32'h000AA0BB, 2'd2, 8'd2, 8'd2, 8'd0, 8'd3, 1'b0, -1);
  endtask

  task automatic test_zero_timing();
    doRequest(1, "zeroClosed", 1'b0, 32'h00000333, 2'd3, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, -1);
    doRequest(0, "zeroOpenMiss", 1'b1, 32'h00004411, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    doRequest(0, "b2b0", 1'b1, 32'h0000A011, 2'd1, 8'd1, 8'd1, 8'd0, 8'd2, 1'b1, -1);
    doRequest(0, "b2b1", 1'b0, 32'h0000A022, 2'd2, 8'd1, 8'd1, 8'd2, 8'd1, 1'b1, -1);
    doRequest(0, "b2b2", 1'b0, 32'h00001233, 2'd3, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0, -1);
  endtask

  task automatic test_max_timing();
    doRequest(0, "maxTiming", 1'b0, 32'h000012FF, 2'd1, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [7:0] rows [3];
    rows[0] = 8'hA0; rows[1] = 8'h12; rows[2] = 8'h33;
    for (int k = 0; k < 25; k++) begin
      doRequest(int'($urandom_range(0, 1)), "random", 1'($urandom),
                {$urandom_range(0, 65535), rows[$urandom_range(0, 2)], 8'($urandom)},
                2'($urandom), 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)), 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_cold_write();
    test_row_hit();
    test_row_miss();
    test_reset_mid();
    test_after_reset();
    test_closed_page();
    test_zero_timing();
    test_back_to_back();
    test_max_timing();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
